gfau_param: RTL and testbench

- Parametrised GF(p) arithmetic unit: modular add, subtract, multiply and divide on W-bit operands with an odd prime modulus p.
- Successor to the fixed 32-bit GF unit. Adds a generic width, a valid/ready handshake, fully reduced results, a divide-by-zero error flag and a single shared result path.
- Sits under the ECC point-arithmetic controller. One operation is in flight at a time.

---
 rtl/gfau_param_if.sv | 25 ++
 rtl/gfau_param.sv | 251 +++++++++++++++++++++++++
 tb/tb_gfau_param.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfau_param_if.sv
// Request/completion bundle of the GF(p) arithmetic unit: operands and op in, reduced result out.
interface gfau_param_if #(
    parameter int W = 32
);
    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_op;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [W-1:0] i_prime;
    logic         o_valid;
    logic [W-1:0] o_result;
    logic         o_err;
    logic         o_busy;

    modport master (
        output i_valid, i_op, i_a, i_b, i_prime,
        input  o_ready, o_valid, o_result, o_err, o_busy
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_prime,
        output o_ready, o_valid, o_result, o_err, o_busy
    );
endinterface

// File: rtl/gfau_param.sv
// GF(p) arithmetic unit: modular add/sub/mult/div on W-bit operands, one operation in flight.
// Define GFAU_RADIX4_MULT_EN to retire two bits of b per multiply cycle (W must then be even).
module gfau_param #(
    parameter int W       = 32,
    parameter int DIV_MAX = 4 * W + 4
) (
    input logic         i_clk,
    input logic         i_rst,
    gfau_param_if.slave bus
);

    typedef enum logic [2:0] {IDLE, EXEC, MLOOP, DLOOP, DFIN, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MULT, OP_DIV} op_t;

`ifdef GFAU_RADIX4_MULT_EN
    localparam int MSTEPS = W / 2;
    localparam int MSHIFT = 2;
`else
    localparam int MSTEPS = W;
    localparam int MSHIFT = 1;
`endif
    localparam int CW  = $clog2(W + 1);
    localparam int DCW = $clog2(DIV_MAX + 1);

    generate
        if (W < 4) begin : g_chkWidth
            $error("gfau_param: W must be at least 4");
        end
`ifdef GFAU_RADIX4_MULT_EN
        if ((W % 2) != 0) begin : g_chkEven
            $error("gfau_param: radix-4 MULT requires an even W");
        end
`endif
    endgenerate

    state_t         state_q;
    op_t            op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   p_q;
    logic [W-1:0]   acc_q;
    logic [CW-1:0]  bitCnt_q;
    logic [W-1:0]   u_q;
    logic [W-1:0]   v_q;
    logic [W-1:0]   x1_q;
    logic [W-1:0]   x2_q;
    logic [DCW-1:0] divCnt_q;
    logic           ready_q;
    logic           valid_q;
    logic           err_q;
    logic [W-1:0]   result_q;

    logic [W-1:0]   addSub_d;
    logic [W-1:0]   acc_d;
    logic [W-1:0]   u_d;
    logic [W-1:0]   v_d;
    logic [W-1:0]   x1_d;
    logic [W-1:0]   x2_d;

    // Sums are formed in W+1 bits so they cannot wrap before the single >= p correction.
    function automatic logic [W-1:0] modAdd(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] p);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return W'(s);
    endfunction

    function automatic logic [W-1:0] modSub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] p);
        logic [W:0] d;
        if (x >= y) d = {1'b0, x} - {1'b0, y};
        else        d = {1'b0, x} + {1'b0, p} - {1'b0, y};
        return W'(d);
    endfunction

    function automatic logic [W-1:0] halve(input logic [W-1:0] x, input logic [W-1:0] p);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
        return W'(s >> 1);
    endfunction

    assign addSub_d = (op_q == OP_SUB) ? modSub(a_q, b_q, p_q) : modAdd(a_q, b_q, p_q);

    // One multiplier step: scale acc by the radix, then add the top digit of b times a.
`ifdef GFAU_RADIX4_MULT_EN
    logic [W-1:0] accX2;
    logic [W-1:0] accX4;
    logic [W-1:0] aX2;
    logic [W-1:0] aX3;
    logic [W-1:0] addend;

    always_comb begin
        accX2 = modAdd(acc_q, acc_q, p_q);
        accX4 = modAdd(accX2, accX2, p_q);
        aX2   = modAdd(a_q, a_q, p_q);
        aX3   = modAdd(aX2, a_q, p_q);
        case (b_q[W-1 -: 2])
            2'd0:    addend = '0;
            2'd1:    addend = a_q;
            2'd2:    addend = aX2;
            default: addend = aX3;
        endcase
        acc_d = modAdd(accX4, addend, p_q);
    end
`else
    logic [W-1:0] accX2;

    always_comb begin
        accX2 = modAdd(acc_q, acc_q, p_q);
        acc_d = b_q[W-1] ? modAdd(accX2, a_q, p_q) : accX2;
    end
`endif

    // Binary inversion keeps x1*b == a*u and x2*b == a*v (mod p), so u==1 leaves a/b in x1.
    always_comb begin
        u_d  = u_q;
        v_d  = v_q;
        x1_d = x1_q;
        x2_d = x2_q;
        if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = halve(x1_q, p_q);
        end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = halve(x2_q, p_q);
        end else if (u_q >= v_q) begin
            u_d  = u_q - v_q;
            x1_d = modSub(x1_q, x2_q, p_q);
        end else begin
            v_d  = v_q - u_q;
            x2_d = modSub(x2_q, x1_q, p_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            bitCnt_q <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            divCnt_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        op_q     <= op_t'(bus.i_op);
                        a_q      <= bus.i_a;
                        b_q      <= bus.i_b;
                        p_q      <= bus.i_prime;
                        acc_q    <= '0;
                        bitCnt_q <= CW'(MSTEPS);
                        ready_q  <= 1'b0;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            result_q <= addSub_d;
                            err_q    <= 1'b0;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                        OP_MULT: begin
                            acc_q    <= acc_d;
                            b_q      <= b_q << MSHIFT;
                            bitCnt_q <= bitCnt_q - 1'b1;
                            state_q  <= MLOOP;
                        end
                        OP_DIV: begin
                            if (b_q == '0) begin
                                result_q <= '0;
                                err_q    <= 1'b1;
                                valid_q  <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                u_q      <= b_q;
                                v_q      <= p_q;
                                x1_q     <= a_q;
                                x2_q     <= '0;
                                divCnt_q <= '0;
                                state_q  <= DLOOP;
                            end
                        end
                    endcase
                end
                MLOOP: begin
                    acc_q    <= acc_d;
                    b_q      <= b_q << MSHIFT;
                    bitCnt_q <= bitCnt_q - 1'b1;
                    if (bitCnt_q == CW'(1)) begin
                        result_q <= acc_d;
                        err_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DLOOP: begin
                    if ((u_q == W'(1)) || (v_q == W'(1))) begin
                        state_q <= DFIN;
                    end else if (divCnt_q == DCW'(DIV_MAX)) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        u_q      <= u_d;
                        v_q      <= v_d;
                        x1_q     <= x1_d;
                        x2_q     <= x2_d;
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                DFIN: begin
                    result_q <= (u_q == W'(1)) ? x1_q : x2_q;
                    err_q    <= 1'b0;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_busy   = ~ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_err    = err_q;

endmodule

// File: tb/tb_gfau_param.sv
// Self-checking bench for gfau_param: fixed vectors, reset/handshake sequences, random ops vs. a
// modular-arithmetic reference model (DIV via Fermat inversion).
module tb_gfau_param;

    localparam int W          = 32;
    localparam int DIV_MAX    = 4 * W + 4;
`ifdef GFAU_RADIX4_MULT_EN
    localparam int MULT_LAT   = W / 2 + 1;
`else
    localparam int MULT_LAT   = W + 1;
`endif
    localparam int WAIT_LIMIT = DIV_MAX + 20;
    localparam int NVEC       = 16;

    logic clk = 1'b0;
    logic rst;

    gfau_param_if #(.W(W)) bus ();

    gfau_param #(.W(W), .DIV_MAX(DIV_MAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] p;
        logic [63:0] expRes;
        logic        expErr;
        logic [31:0] expLat;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mkVec(input int op, input longint unsigned a, input longint unsigned b,
                                   input longint unsigned p, input longint unsigned expRes,
                                   input int expErr, input int expLat);
        vec_t v;
        v.op     = op[1:0];
        v.a      = a;
        v.b      = b;
        v.p      = p;
        v.expRes = expRes;
        v.expErr = expErr[0];
        v.expLat = expLat;
        return v;
    endfunction

    function automatic longint unsigned powMod(input longint unsigned base, input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r  = 1;
        longint unsigned bb = base % m;
        longint unsigned ee = e;
        while (ee != 0) begin
            if ((ee & 64'd1) != 0) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >> 1;
        end
        return r;
    endfunction

    function automatic longint unsigned refModel(input int op, input longint unsigned a,
                                                 input longint unsigned b, input longint unsigned p,
                                                 output logic err);
        err = 1'b0;
        case (op)
            0: return (a + b) % p;
            1: return (a + p - b) % p;
            2: return (a * b) % p;
            default: begin
                if (b == 0) begin
                    err = 1'b1;
                    return 0;
                end
                return (a * powMod(b, p - 2, p)) % p;
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: no response within %0d cycles", name, WAIT_LIMIT);
    endtask

    task automatic waitReady(output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus.o_ready !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.o_ready === 1'b1);
    endtask

    // Issues one request, then counts negedges from the accept edge until o_valid (accept cycle = 0).
    task automatic applyStimulus(input logic [1:0] op, input longint unsigned a, input longint unsigned b,
                                 input longint unsigned p, output logic [63:0] res, output logic err,
                                 output int lat);
        bit ok;
        lat = -1;
        res = '0;
        err = 1'b0;
        waitReady(ok);
        if (!ok) begin
            reportTimeout("ready wait");
            return;
        end
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = W'(a);
        bus.i_b     = W'(b);
        bus.i_prime = W'(p);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        for (int k = 1; k <= WAIT_LIMIT; k++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                lat = k;
                res = 64'(bus.o_result);
                err = bus.o_err;
                break;
            end
        end
        if (lat < 0) reportTimeout("completion wait");
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0]     res;
        logic            err;
        logic            expErr;
        int              lat;
        int              pulses;
        bit              ok;
        bit              readyLow;
        logic [1:0]      op;
        longint unsigned a, b, p, expRes;
        longint unsigned primes [6];

        primes = '{64'd97, 64'd251, 64'd65521, 64'd1000003, 64'd2147483647, 64'd4294967291};

        vecs[0]  = mkVec(0, 96, 96, 97, 95, 0, 2);
        vecs[1]  = mkVec(0, 60, 50, 97, 13, 0, 2);
        vecs[2]  = mkVec(1, 10, 20, 97, 87, 0, 2);
        vecs[3]  = mkVec(1, 5, 5, 97, 0, 0, 2);
        vecs[4]  = mkVec(0, 96, 1, 97, 0, 0, 2);
        vecs[5]  = mkVec(1, 0, 96, 97, 1, 0, 2);
        vecs[6]  = mkVec(2, 45, 3, 97, 38, 0, MULT_LAT);
        vecs[7]  = mkVec(2, 64'd4294967290, 64'd4294967290, 64'd4294967291, 1, 0, MULT_LAT);
        vecs[8]  = mkVec(2, 0, 55, 97, 0, 0, MULT_LAT);
        vecs[9]  = mkVec(2, 55, 0, 97, 0, 0, MULT_LAT);
        vecs[10] = mkVec(2, 96, 96, 97, 1, 0, MULT_LAT);
        vecs[11] = mkVec(3, 10, 3, 97, 68, 0, 0);
        vecs[12] = mkVec(3, 1, 96, 97, 96, 0, 0);
        vecs[13] = mkVec(3, 7, 0, 97, 0, 1, 2);
        vecs[14] = mkVec(3, 5, 1, 97, 5, 0, 0);
        vecs[15] = mkVec(3, 0, 42, 97, 0, 0, 0);

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_op    = 2'd0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_prime = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset o_ready", 64'(bus.o_ready), 1);
        checkOutput("reset o_valid", 64'(bus.o_valid), 0);
        checkOutput("reset o_result", 64'(bus.o_result), 0);
        checkOutput("reset o_err", 64'(bus.o_err), 0);
        checkOutput("reset o_busy", 64'(bus.o_busy), 0);
        rst = 1'b0;

        // Abort a MULT with reset: no completion may ever appear for it.
        waitReady(ok);
        bus.i_valid = 1'b1;
        bus.i_op    = 2'd2;
        bus.i_a     = W'(45);
        bus.i_b     = W'(3);
        bus.i_prime = W'(97);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("mid-mult o_busy", 64'(bus.o_busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("abort o_ready", 64'(bus.o_ready), 1);
        checkOutput("abort o_valid", 64'(bus.o_valid), 0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        @(negedge clk);
        checkOutput("post-abort o_ready", 64'(bus.o_ready), 1);
        for (int k = 0; k < MULT_LAT + 10; k++) begin
            if (bus.o_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checkOutput("post-abort pulses", 64'(pulses), 0);
        applyStimulus(2'd0, 1, 1, 97, res, err, lat);
        if (lat > 0) checkOutput("post-abort add", res, 2);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p, res, err, lat);
            if (lat > 0) begin
                checkOutput($sformatf("vec%0d result", i), res, vecs[i].expRes);
                checkOutput($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].expErr));
                if (vecs[i].expLat != 0)
                    checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
                else
                    checkOutput($sformatf("vec%0d latency<=DIV_MAX", i), 64'(lat <= DIV_MAX), 1);
                @(negedge clk);
                checkOutput($sformatf("vec%0d single pulse", i), 64'(bus.o_valid), 0);
                checkOutput($sformatf("vec%0d ready after", i), 64'(bus.o_ready), 1);
            end
        end

        // Illegal DIV (b == p) must still complete.
        applyStimulus(2'd3, 5, 97, 97, res, err, lat);
        checkOutput("illegal div completes", 64'(lat > 0), 1);

        // Hold i_valid during a MULT with changing operands; only the first request may count.
        waitReady(ok);
        bus.i_valid = 1'b1;
        bus.i_op    = 2'd2;
        bus.i_a     = W'(45);
        bus.i_b     = W'(3);
        bus.i_prime = W'(97);
        @(posedge clk);
        #1;
        lat      = -1;
        readyLow = 1'b1;
        for (int k = 1; k <= WAIT_LIMIT; k++) begin
            @(negedge clk);
            if (bus.o_ready !== 1'b0) readyLow = 1'b0;
            if (bus.o_valid === 1'b1) begin
                lat = k;
                res = 64'(bus.o_result);
                break;
            end
            bus.i_op = 2'($urandom_range(3));
            bus.i_a  = W'($urandom_range(96));
            bus.i_b  = W'($urandom_range(96));
        end
        if (lat < 0) reportTimeout("held-valid mult");
        else begin
            checkOutput("held-valid result", res, 38);
            checkOutput("held-valid latency", 64'(lat), 64'(MULT_LAT));
            checkOutput("held-valid ready low", 64'(readyLow), 1);
            bus.i_op = 2'd0;
            bus.i_a  = W'(96);
            bus.i_b  = W'(96);
            @(negedge clk);
            checkOutput("back-to-back ready", 64'(bus.o_ready), 1);
            @(posedge clk);
            #1 bus.i_valid = 1'b0;
            lat = -1;
            for (int k = 1; k <= WAIT_LIMIT; k++) begin
                @(negedge clk);
                if (bus.o_valid === 1'b1) begin
                    lat = k;
                    res = 64'(bus.o_result);
                    break;
                end
            end
            if (lat < 0) reportTimeout("back-to-back add");
            else begin
                checkOutput("back-to-back result", res, 95);
                checkOutput("back-to-back latency", 64'(lat), 2);
            end
        end
        bus.i_valid = 1'b0;

        for (int i = 0; i < 1200; i++) begin
            p  = primes[$urandom_range(5)];
            a  = 64'($urandom) % p;
            b  = 64'($urandom) % p;
            op = (i < 1000) ? 2'd2 : 2'($urandom_range(3));
            if (op == 2'd3 && (i % 40) == 0) b = 0;
            expRes = refModel(int'(op), a, b, p, expErr);
            applyStimulus(op, a, b, p, res, err, lat);
            if (lat > 0) begin
                checkOutput($sformatf("rand%0d op%0d result", i, op), res, expRes);
                checkOutput($sformatf("rand%0d op%0d err", i, op), 64'(err), 64'(expErr));
                if (op == 2'd2)
                    checkOutput($sformatf("rand%0d latency", i), 64'(lat), 64'(MULT_LAT));
                else if (op == 2'd3 && !expErr)
                    checkOutput($sformatf("rand%0d latency<=DIV_MAX", i), 64'(lat <= DIV_MAX), 1);
                else
                    checkOutput($sformatf("rand%0d latency", i), 64'(lat), 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
